// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the LED matrix framebuffer and scan path.
package led_matrix_pkg;

    localparam int unsigned COLS      = 32;
    localparam int unsigned ROWS      = 16;
    localparam int unsigned SCAN_ROWS = ROWS / 2;
    localparam int unsigned FB_ADDR_W = 9;
    localparam int unsigned PIX_W     = 4;
    localparam int unsigned COL_W     = $clog2(COLS);
    localparam int unsigned ROW_W     = $clog2(SCAN_ROWS);

    localparam int unsigned PIX_R = 0;
    localparam int unsigned PIX_G = 1;
    localparam int unsigned PIX_B = 2;

    typedef enum logic [1:0] {
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb_t;

    typedef struct packed {
        rgb_t upper;
        rgb_t lower;
    } rgb_pair_t;

    function automatic rgb_t pix_to_rgb(input logic [PIX_B:0] pix);
        rgb_t rgb;
        rgb.r = pix[PIX_R];
        rgb.g = pix[PIX_G];
        rgb.b = pix[PIX_B];
        return rgb;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Framebuffer read port plus HUB75 panel pins driven by the scan driver.
interface matrix_scan_driver_if;
    import led_matrix_pkg::*;

    logic [FB_ADDR_W-1:0] fb_raddr;
    logic [PIX_W-1:0]     fb_rdata;
    logic                 mat_r1;
    logic                 mat_g1;
    logic                 mat_b1;
    logic                 mat_r2;
    logic                 mat_g2;
    logic                 mat_b2;
    logic                 mat_clk;
    logic                 mat_lat;
    logic                 mat_oe_n;
    logic [ROW_W-1:0]     mat_a;
    logic                 frame_done;

    modport master (
        output fb_raddr,
        input  fb_rdata,
        output mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2,
        output mat_clk, mat_lat, mat_oe_n, mat_a, frame_done
    );

    modport slave (
        input  fb_raddr,
        output fb_rdata,
        input  mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2,
        input  mat_clk, mat_lat, mat_oe_n, mat_a, frame_done
    );

endinterface

// File: rtl/matrix_scan_driver.sv
// Free-running 1/8-scan HUB75 driver: reads framebuffer pixels, shifts each
// row pair out, blanks, latches, then lights the row for ON_CYCLES clocks.
module matrix_scan_driver
    import led_matrix_pkg::*;
#(
    parameter int unsigned ON_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_scan_driver_if.master bus
);

    localparam int unsigned      ON_W     = $clog2(ON_CYCLES + 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);

    scan_state_t          state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [1:0]           phase_q, phase_d;
    logic [ON_W-1:0]      on_cnt_q, on_cnt_d;
    rgb_t                 upper_q, upper_d;
    rgb_pair_t            rgb_q, rgb_d;
    logic [FB_ADDR_W-1:0] raddr_q, raddr_d;
    logic                 mclk_q, mclk_d;
    logic                 lat_q, lat_d;
    logic                 oe_n_q, oe_n_d;
    logic                 done_q, done_d;
    logic [ROW_W-1:0]     mat_a_q, mat_a_d;
    logic                 fb_rdata_unused;

    // Bit 3 of a pixel carries no colour on this panel.
    assign fb_rdata_unused = bus.fb_rdata[PIX_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SHIFT;
            row_q    <= '0;
            col_q    <= '0;
            phase_q  <= '0;
            on_cnt_q <= '0;
            upper_q  <= '0;
            rgb_q    <= '0;
            raddr_q  <= '0;
            mclk_q   <= 1'b0;
            lat_q    <= 1'b0;
            oe_n_q   <= 1'b1;
            done_q   <= 1'b0;
            mat_a_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            phase_q  <= phase_d;
            on_cnt_q <= on_cnt_d;
            upper_q  <= upper_d;
            rgb_q    <= rgb_d;
            raddr_q  <= raddr_d;
            mclk_q   <= mclk_d;
            lat_q    <= lat_d;
            oe_n_q   <= oe_n_d;
            done_q   <= done_d;
            mat_a_q  <= mat_a_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        phase_d  = phase_q;
        on_cnt_d = on_cnt_q;
        upper_d  = upper_q;
        rgb_d    = rgb_q;
        raddr_d  = raddr_q;
        mclk_d   = 1'b0;
        lat_d    = 1'b0;
        oe_n_d   = 1'b1;
        done_d   = 1'b0;
        mat_a_d  = mat_a_q;

        unique case (state_q)
            SHIFT: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd1) begin
                    upper_d = pix_to_rgb(bus.fb_rdata[PIX_B:0]);
                end
                if (phase_q == 2'd2) begin
                    rgb_d.upper = upper_q;
                    rgb_d.lower = pix_to_rgb(bus.fb_rdata[PIX_B:0]);
                end
                if (phase_q == 2'd3) begin
                    mclk_d = 1'b1;
                    col_d  = col_q + COL_W'(1);
                    if (col_q == COL_LAST) begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                state_d = LATCH;
            end
            LATCH: begin
                lat_d    = 1'b1;
                mat_a_d  = row_q;
                on_cnt_d = '0;
                state_d  = DISPLAY;
            end
            DISPLAY: begin
                oe_n_d   = 1'b0;
                on_cnt_d = on_cnt_q + ON_W'(1);
                if (on_cnt_q == ON_LAST) begin
                    on_cnt_d = '0;
                    row_d    = row_q + ROW_W'(1);
                    done_d   = (row_q == ROW_LAST);
                    state_d  = SHIFT;
                end
            end
            default: state_d = SHIFT;
        endcase

        // Address register leads by one so it is valid in the phase that uses it.
        if (state_d == SHIFT && phase_d < 2'd2) begin
            raddr_d = {phase_d[0], row_d, col_d};
        end
    end

    assign bus.fb_raddr   = raddr_q;
    assign bus.mat_r1     = rgb_q.upper.r;
    assign bus.mat_g1     = rgb_q.upper.g;
    assign bus.mat_b1     = rgb_q.upper.b;
    assign bus.mat_r2     = rgb_q.lower.r;
    assign bus.mat_g2     = rgb_q.lower.g;
    assign bus.mat_b2     = rgb_q.lower.b;
    assign bus.mat_clk    = mclk_q;
    assign bus.mat_lat    = lat_q;
    assign bus.mat_oe_n   = oe_n_q;
    assign bus.mat_a      = mat_a_q;
    assign bus.frame_done = done_q;

endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Downstream consumer of the framebuffer written by the number-writer FSM: continuously reads 4-bit pixels from the framebuffer read port and drives a 32x16, 1/8-scan HUB75-style LED panel. Each row pair (r, r+8) is shifted out serially, blanked, latched, then displayed for a programmable on-time. The block runs free after reset and never stalls; framebuffer writes proceed independently on the write port.

## Interface
- COLS, 32, panel columns (pixels shifted per row pair)
- ROWS, 16, panel rows; scan rows = ROWS/2 = 8
- ON_CYCLES, 256, clk cycles OE is active per row pair (>=1)
- clk  in  1  system clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- fb_raddr  out  9  framebuffer read address {row[3:0], col[4:0]}
- fb_rdata  in  4  framebuffer read data, valid 1 cycle after fb_raddr; [0]=R, [1]=G, [2]=B, [3] ignored
- mat_r1, mat_g1, mat_b1  out  1 each  upper-half colour bits (row r)
- mat_r2, mat_g2, mat_b2  out  1 each  lower-half colour bits (row r+8)
- mat_clk  out  1  panel shift clock, data sampled by panel on rising edge
- mat_lat  out  1  panel latch, active high
- mat_oe_n  out  1  panel output enable, active low
- mat_a  out  3  panel row-pair address
- frame_done  out  1  one-cycle pulse at end of row pair 7 display

## Operation
- Registers: scan row r (3 b), column c (5 b), phase p (2 b), on-time counter (ceil(log2(ON_CYCLES+1)) b).
- States: SHIFT, BLANK, LATCH, DISPLAY.
- SHIFT, per column, 4 phases:
  - p=0: fb_raddr = {0,r,c} (upper pixel).
  - p=1: fb_raddr = {1,r,c} (lower pixel); capture fb_rdata[2:0] into upper holding reg.
  - p=2: capture fb_rdata[2:0] into lower holding reg; drive both regs onto mat_r1..mat_b2.
  - p=3: mat_clk=1; colour outputs held stable. c increments; after c=COLS-1 at p=3, c wraps to 0, go BLANK.
- BLANK: mat_oe_n=1 for 1 cycle -> LATCH.
- LATCH: mat_lat=1 for 1 cycle; mat_a <= r on exit -> DISPLAY.
- DISPLAY: mat_oe_n=0 for exactly ON_CYCLES cycles; on last cycle r increments (7 wraps to 0), frame_done=1 if r was 7 -> SHIFT.
- mat_oe_n=1 in SHIFT, BLANK, LATCH (panel dark while shifting; no ghosting).
- Framebuffer writes during a scan are not synchronised; a pixel changed mid-frame appears on next read of that address.

## Timing
- Reset values: state=SHIFT, r=0, c=0, p=0, fb_raddr=0, all colour outputs 0, mat_clk=0, mat_lat=0, mat_oe_n=1, mat_a=0, frame_done=0.
- All outputs registered except fb_raddr (registered too; value applies in phase cycle listed).
- First mat_clk high: cycle 4 after rst deasserts (cycles counted from 1).
- Row period = 4*COLS + 2 + ON_CYCLES = 386 cycles at defaults; frame period = 8x that = 3088.
- mat_clk high exactly 1 of every 4 SHIFT cycles; colour data stable from 1 cycle before to 1 cycle after rising mat_clk.
- mat_lat never asserted while mat_oe_n=0; mat_a changes only while mat_oe_n=1.
- rst asserted mid-operation (any state): next cycle all outputs at reset values; scan restarts at row 0 col 0.

## Structure
- Shared package led_matrix_pkg: COLS, ROWS, SCAN_ROWS, FB_ADDR_W=9, PIX_W=4, pixel bit indices, scan state enum (SHIFT/BLANK/LATCH/DISPLAY).
- Single module; counters and FSM inline. No sub-module required.

## Test plan
- Reset release with framebuffer all zero -> mat_oe_n=1 through SHIFT, 32 mat_clk pulses, all colour outputs 0, mat_lat pulse at cycle 130, mat_oe_n low cycles 131..386.
- Framebuffer model with pixel(row,col)=row*32+col low 3 bits -> upper/lower colour bits at each mat_clk rising edge match address {0,r,c}/{1,r,c}; fb_raddr sequence checked per phase.
- Full frame run -> mat_a sequence 0..7 then 0; frame_done single pulse every 3088 cycles.
- ON_CYCLES=1 build -> DISPLAY lasts exactly 1 cycle; row period 131.
- rst asserted during DISPLAY of row 5 and during SHIFT col 17 -> outputs at reset values next cycle; restart at row 0 col 0.
- Framebuffer write to (row 3, col 10) during frame -> new value shifted on next scan of row pair 3; assertion checkers: mat_lat&~mat_oe_n never true, mat_a stable while mat_oe_n=0.
